// File: rtl/aging_vec_engine.sv
// aging_vec_engine: table-driven stimulus/response engine for combinational
// benchmark aging runs. Each stored vector is applied for SETTLE cycles.
// The benchmark response is then sampled and compared with the stored
// expectation, and the compare result is counted and logged.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   load_en/addr/vec/exp      table write port (accepted only while idle)
//   start, loop_mode, stop    run control
//   dut_in, dut_out           benchmark stimulus / response
//   busy, done, vec_idx       run status
//   resp_valid, resp_data     sampled response strobe
//   mismatch_cnt, pass_cnt    saturating fail count, wrapping pass count
//   first_fail_valid/idx      first mismatching vector of the run
module aging_vec_engine #(
    parameter int unsigned IN_W   = 5,
    parameter int unsigned OUT_W  = 2,
    parameter int unsigned DEPTH  = 30,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_vec,
    input  logic [OUT_W-1:0] load_exp,
    input  logic             start,
    input  logic             loop_mode,
    input  logic             stop,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    vec_idx,
    output logic             resp_valid,
    output logic [OUT_W-1:0] resp_data,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      pass_cnt,
    output logic             first_fail_valid,
    output logic [AW-1:0]    first_fail_idx
);

    localparam int unsigned HW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t           state;
    logic [HW-1:0]    hold;
    logic             loop_r;
    logic             stop_seen;

    logic [IN_W-1:0]  vec_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem [DEPTH];

    logic             sample_c;
    logic             is_last_c;
    logic             end_run_c;
    logic [AW-1:0]    next_idx_c;

    // Table write port; contents survive reset and are frozen during a run.
    always_ff @(posedge clk) begin
        if (load_en && (state == IDLE) && (32'(load_addr) < DEPTH)) begin
            vec_mem[load_addr] <= load_vec;
            exp_mem[load_addr] <= load_exp;
        end
    end

    // Vector boundary decode: sample point, wrap index and run termination.
    always_comb begin
        sample_c   = (state == APPLY) && (hold == HOLD_LAST);
        is_last_c  = (vec_idx == LAST_IDX);
        next_idx_c = is_last_c ? '0 : vec_idx + AW'(1);
        // A stop pulse landing exactly on the boundary counts as seen.
        end_run_c  = (loop_r && (stop_seen || stop)) || (is_last_c && !loop_r);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            hold             <= '0;
            loop_r           <= 1'b0;
            stop_seen        <= 1'b0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            vec_idx          <= '0;
            resp_valid       <= 1'b0;
            resp_data        <= '0;
            mismatch_cnt     <= '0;
            pass_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            done       <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state            <= APPLY;
                        busy             <= 1'b1;
                        hold             <= '0;
                        vec_idx          <= '0;
                        dut_in           <= vec_mem[0];
                        loop_r           <= loop_mode;
                        stop_seen        <= 1'b0;
                        mismatch_cnt     <= '0;
                        pass_cnt         <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                    end
                end
                APPLY: begin
                    if (loop_r && stop) begin
                        stop_seen <= 1'b1;
                    end
                    if (sample_c) begin
                        hold       <= '0;
                        resp_valid <= 1'b1;
                        resp_data  <= dut_out;
                        if (dut_out != exp_mem[vec_idx]) begin
                            if (mismatch_cnt != 16'hFFFF) begin
                                mismatch_cnt <= mismatch_cnt + 16'd1;
                            end
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_idx   <= vec_idx;
                            end
                        end
                        if (is_last_c) begin
                            pass_cnt <= pass_cnt + 16'd1;
                        end
                        if (end_run_c) begin
                            state <= DONE;
                        end else begin
                            vec_idx <= next_idx_c;
                            dut_in  <= vec_mem[next_idx_c];
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aging_vec_engine.sv
// Directed bench for aging_vec_engine. Three instances share one clock:
// u_a (DEPTH 30, SETTLE 1), u_b (DEPTH 30, SETTLE 3), u_c (DEPTH 2,
// SETTLE 1). Each instance drives a c17 model as its benchmark.
module tb_aging_vec_engine;

    logic clk;
    logic rst;

    // Shared write data for u_a / u_b, separate enables.
    logic       ld_a, ld_b;
    logic [4:0] ld_addr;
    logic [4:0] ld_vec;
    logic [1:0] ld_exp;

    logic start_a, loop_a, stop_a;
    logic start_b, loop_b, stop_b;

    logic [4:0]  dut_in_a, vec_idx_a, ffi_a;
    logic [1:0]  dut_out_a, resp_data_a;
    logic        busy_a, done_a, resp_valid_a, ffv_a;
    logic [15:0] mis_a, pass_a;

    logic [4:0]  dut_in_b, vec_idx_b, ffi_b;
    logic [1:0]  dut_out_b, resp_data_b;
    logic        busy_b, done_b, resp_valid_b, ffv_b;
    logic [15:0] mis_b, pass_b;

    logic        ld_c, start_c, loop_c, stop_c;
    logic [0:0]  ld_addr_c, vec_idx_c, ffi_c;
    logic [4:0]  ld_vec_c, dut_in_c;
    logic [1:0]  ld_exp_c, dut_out_c, resp_data_c;
    logic        busy_c, done_c, resp_valid_c, ffv_c;
    logic [15:0] mis_c, pass_c;

    logic [4:0] tbl_vec [30];
    logic [1:0] tbl_exp [30];

    int n_cmp = 0;
    int n_err = 0;

    // ISCAS-85 c17: inputs {N7,N6,N3,N2,N1}, outputs {N23,N22}.
    function automatic logic [1:0] c17(input logic [4:0] x);
        logic n10, n11, n16, n19;
        n10 = ~(x[0] & x[2]);
        n11 = ~(x[2] & x[3]);
        n16 = ~(x[1] & n11);
        n19 = ~(n11 & x[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    assign dut_out_a = c17(dut_in_a);
    assign dut_out_b = c17(dut_in_b);
    assign dut_out_c = c17(dut_in_c);

    aging_vec_engine #(.IN_W(5), .OUT_W(2), .DEPTH(30), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .load_en(ld_a), .load_addr(ld_addr),
        .load_vec(ld_vec), .load_exp(ld_exp), .start(start_a),
        .loop_mode(loop_a), .stop(stop_a), .dut_in(dut_in_a),
        .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .vec_idx(vec_idx_a), .resp_valid(resp_valid_a),
        .resp_data(resp_data_a), .mismatch_cnt(mis_a), .pass_cnt(pass_a),
        .first_fail_valid(ffv_a), .first_fail_idx(ffi_a));

    aging_vec_engine #(.IN_W(5), .OUT_W(2), .DEPTH(30), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .load_en(ld_b), .load_addr(ld_addr),
        .load_vec(ld_vec), .load_exp(ld_exp), .start(start_b),
        .loop_mode(loop_b), .stop(stop_b), .dut_in(dut_in_b),
        .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .vec_idx(vec_idx_b), .resp_valid(resp_valid_b),
        .resp_data(resp_data_b), .mismatch_cnt(mis_b), .pass_cnt(pass_b),
        .first_fail_valid(ffv_b), .first_fail_idx(ffi_b));

    aging_vec_engine #(.IN_W(5), .OUT_W(2), .DEPTH(2), .SETTLE(1)) u_c (
        .clk(clk), .rst(rst), .load_en(ld_c), .load_addr(ld_addr_c),
        .load_vec(ld_vec_c), .load_exp(ld_exp_c), .start(start_c),
        .loop_mode(loop_c), .stop(stop_c), .dut_in(dut_in_c),
        .dut_out(dut_out_c), .busy(busy_c), .done(done_c),
        .vec_idx(vec_idx_c), .resp_valid(resp_valid_c),
        .resp_data(resp_data_c), .mismatch_cnt(mis_c), .pass_cnt(pass_c),
        .first_fail_valid(ffv_c), .first_fail_idx(ffi_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks enter and leave just after a rising edge.
    task automatic load_entry(input logic to_a, input logic to_b,
                              input logic [4:0] addr, input logic [4:0] v,
                              input logic [1:0] e);
        ld_a = to_a; ld_b = to_b; ld_addr = addr; ld_vec = v; ld_exp = e;
        @(posedge clk); #1;
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    task automatic pulse_start_a(input logic lp);
        start_a = 1'b1; loop_a = lp;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Observes a u_a run; cyc 0 is the cycle right after the start edge.
    // mode 1: load/start/stop while busy; mode 2: stop at pass 3 vector 12.
    task automatic watch_a(input int mode, input int max_cyc,
                           output int strobes, output int first_s,
                           output int last_s, output int done_cyc,
                           output int data_err, output int last_vec,
                           output logic busy0, output logic [4:0] din0);
        strobes = 0; first_s = -1; last_s = -1; done_cyc = -1;
        data_err = 0; last_vec = -1; busy0 = 1'b0; din0 = '0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                busy0 = busy_a; din0 = dut_in_a;
            end
            if (mode == 1 && cyc == 5) begin
                ld_a = 1'b1; ld_addr = 5'd0; ld_vec = ~tbl_vec[0];
                ld_exp = ~tbl_exp[0]; start_a = 1'b1; stop_a = 1'b1;
            end else if (mode == 1 && cyc == 6) begin
                ld_a = 1'b0; start_a = 1'b0; stop_a = 1'b0;
            end
            if (mode == 2)
                stop_a = busy_a && (pass_a == 16'd2) && (vec_idx_a == 5'd12);
            if (resp_valid_a) begin
                if (resp_data_a !== c17(tbl_vec[strobes % 30])) data_err++;
                if (first_s < 0) first_s = cyc;
                last_s = cyc;
                last_vec = strobes % 30;
                strobes++;
            end
            if (done_a) begin
                done_cyc = cyc;
                break;
            end
        end
        stop_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({dut_in_a, busy_a, done_a, vec_idx_a, resp_valid_a, resp_data_a,
             mis_a, pass_a, ffv_a, ffi_a} !== 53'd0) begin
            n_err++; $display("FAIL reset_a: outputs not at reset values (busy=%0b mis=%0h)", busy_a, mis_a);
        end
        n_cmp++;
        if ({dut_in_b, busy_b, done_b, vec_idx_b, resp_valid_b, resp_data_b,
             mis_b, pass_b, ffv_b, ffi_b} !== 53'd0) begin
            n_err++; $display("FAIL reset_b: outputs not at reset values (busy=%0b mis=%0h)", busy_b, mis_b);
        end
        n_cmp++;
        if ({dut_in_c, busy_c, done_c, vec_idx_c, resp_valid_c, resp_data_c,
             mis_c, pass_c, ffv_c, ffi_c} !== 45'd0) begin
            n_err++; $display("FAIL reset_c: outputs not at reset values (busy=%0b mis=%0h)", busy_c, mis_c);
        end
    endtask

    task automatic test_reset_mid_run();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) load_entry(1'b1, 1'b0, 5'(i), tbl_vec[i], tbl_exp[i]);
        pulse_start_a(1'b0);
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge clk);
            if (vec_idx_a == 5'd10) found = 1'b1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL midrst_reach_vec10: got %0b expected 1", found);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_in_a, busy_a, done_a, vec_idx_a, resp_valid_a, resp_data_a,
             mis_a, pass_a, ffv_a, ffi_a} !== 53'd0) begin
            n_err++; $display("FAIL midrst_clear: busy=%0b vec_idx=%0d dut_in=%0h expected all zero", busy_a, vec_idx_a, dut_in_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_golden(input string tag);
        int s, fs, ls, dc, de, lv;
        logic b0;
        logic [4:0] d0;
        pulse_start_a(1'b0);
        watch_a(0, 100, s, fs, ls, dc, de, lv, b0, d0);
        n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL %s_busy_at_start: got %0b expected 1", tag, b0); end
        n_cmp++; if (d0 !== tbl_vec[0]) begin n_err++; $display("FAIL %s_dut_in0: got %0h expected %0h", tag, d0, tbl_vec[0]); end
        n_cmp++; if (s !== 30) begin n_err++; $display("FAIL %s_strobes: got %0d expected 30", tag, s); end
        n_cmp++; if (fs !== 1) begin n_err++; $display("FAIL %s_first_strobe: got %0d expected 1", tag, fs); end
        n_cmp++; if (dc !== 31 || ls !== 30) begin n_err++; $display("FAIL %s_done_timing: done %0d last strobe %0d expected 31/30", tag, dc, ls); end
        n_cmp++; if (de !== 0) begin n_err++; $display("FAIL %s_resp_data: got %0d bad expected 0", tag, de); end
        n_cmp++; if (mis_a !== 16'd0) begin n_err++; $display("FAIL %s_mismatch: got %0d expected 0", tag, mis_a); end
        n_cmp++; if (pass_a !== 16'd1) begin n_err++; $display("FAIL %s_pass: got %0d expected 1", tag, pass_a); end
        n_cmp++; if (busy_a !== 1'b0 || ffv_a !== 1'b0) begin n_err++; $display("FAIL %s_idle: busy %0b ffv %0b expected 0/0", tag, busy_a, ffv_a); end
    endtask

    task automatic test_fault_injection();
        int strobes, spacing_err, done_cyc;
        strobes = 0; spacing_err = 0; done_cyc = -1;
        for (int i = 0; i < 30; i++)
            load_entry(1'b0, 1'b1, 5'(i), tbl_vec[i],
                       (i == 4 || i == 17) ? (tbl_exp[i] ^ 2'b01) : tbl_exp[i]);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (resp_valid_b) begin
                if (cyc != 3 * (strobes + 1)) spacing_err++;
                strobes++;
            end
            if (done_b) begin
                done_cyc = cyc;
                break;
            end
        end
        n_cmp++; if (strobes !== 30) begin n_err++; $display("FAIL fault_strobes: got %0d expected 30", strobes); end
        n_cmp++; if (spacing_err !== 0) begin n_err++; $display("FAIL fault_spacing: got %0d off-grid expected 0", spacing_err); end
        n_cmp++; if (done_cyc !== 91) begin n_err++; $display("FAIL fault_done_cycle: got %0d expected 91", done_cyc); end
        n_cmp++; if (mis_b !== 16'd2) begin n_err++; $display("FAIL fault_mismatch: got %0d expected 2", mis_b); end
        n_cmp++; if (ffv_b !== 1'b1 || ffi_b !== 5'd4) begin n_err++; $display("FAIL fault_first_fail: valid %0b idx %0d expected 1/4", ffv_b, ffi_b); end
        @(posedge clk); #1;
    endtask

    task automatic test_loop_stop();
        int s, fs, ls, dc, de, lv;
        logic b0;
        logic [4:0] d0;
        pulse_start_a(1'b1);
        watch_a(2, 300, s, fs, ls, dc, de, lv, b0, d0);
        loop_a = 1'b0;
        n_cmp++; if (s !== 73) begin n_err++; $display("FAIL loop_strobes: got %0d expected 73", s); end
        n_cmp++; if (lv !== 12) begin n_err++; $display("FAIL loop_last_vec: got %0d expected 12", lv); end
        n_cmp++; if (dc !== 74 || ls !== 73) begin n_err++; $display("FAIL loop_done_timing: done %0d last strobe %0d expected 74/73", dc, ls); end
        n_cmp++; if (pass_a !== 16'd2) begin n_err++; $display("FAIL loop_pass: got %0d expected 2", pass_a); end
        n_cmp++; if (mis_a !== 16'd0 || de !== 0) begin n_err++; $display("FAIL loop_data: mismatch %0d bad %0d expected 0/0", mis_a, de); end
    endtask

    task automatic test_ignored_controls();
        int s, fs, ls, dc, de, lv;
        logic b0;
        logic [4:0] d0;
        pulse_start_a(1'b0);
        watch_a(1, 100, s, fs, ls, dc, de, lv, b0, d0);
        n_cmp++; if (s !== 30) begin n_err++; $display("FAIL ign_strobes: got %0d expected 30", s); end
        n_cmp++; if (dc !== 31) begin n_err++; $display("FAIL ign_done_cycle: got %0d expected 31", dc); end
        n_cmp++; if (mis_a !== 16'd0 || de !== 0) begin n_err++; $display("FAIL ign_data: mismatch %0d bad %0d expected 0/0", mis_a, de); end
        load_entry(1'b1, 1'b0, 5'd31, 5'h1F, 2'b10);
        test_golden("ign_rerun");
    endtask

    task automatic test_saturation();
        logic seen100, fin;
        seen100 = 1'b0; fin = 1'b0;
        ld_c = 1'b1; ld_addr_c = 1'b0; ld_vec_c = 5'h00; ld_exp_c = ~c17(5'h00);
        @(posedge clk); #1;
        ld_addr_c = 1'b1; ld_vec_c = 5'h1F; ld_exp_c = ~c17(5'h1F);
        @(posedge clk); #1;
        ld_c = 1'b0;
        start_c = 1'b1; loop_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        for (int cyc = 0; cyc < 70000 && !fin; cyc++) begin
            @(negedge clk);
            if (pass_c == 16'd100 && !seen100) begin
                seen100 = 1'b1;
                n_cmp++;
                if (mis_c !== 16'd200) begin n_err++; $display("FAIL sat_count_at_100: got %0d expected 200", mis_c); end
            end
            stop_c = (pass_c == 16'd32770);
            if (done_c) fin = 1'b1;
        end
        stop_c = 1'b0; loop_c = 1'b0;
        n_cmp++; if (fin !== 1'b1 || seen100 !== 1'b1) begin n_err++; $display("FAIL sat_run_end: done %0b seen100 %0b expected 1/1", fin, seen100); end
        n_cmp++; if (mis_c !== 16'hFFFF) begin n_err++; $display("FAIL sat_mismatch: got %0h expected ffff", mis_c); end
        n_cmp++; if (pass_c !== 16'd32770) begin n_err++; $display("FAIL sat_pass: got %0d expected 32770", pass_c); end
        n_cmp++; if (ffv_c !== 1'b1 || ffi_c !== 1'b0) begin n_err++; $display("FAIL sat_first_fail: valid %0b idx %0d expected 1/0", ffv_c, ffi_c); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        ld_a = 1'b0; ld_b = 1'b0; ld_addr = '0; ld_vec = '0; ld_exp = '0;
        start_a = 1'b0; loop_a = 1'b0; stop_a = 1'b0;
        start_b = 1'b0; loop_b = 1'b0; stop_b = 1'b0;
        ld_c = 1'b0; ld_addr_c = '0; ld_vec_c = '0; ld_exp_c = '0;
        start_c = 1'b0; loop_c = 1'b0; stop_c = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tbl_vec[i] = 5'(i * 7 + 3);
            tbl_exp[i] = c17(tbl_vec[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset_mid_run();
        test_golden("golden");
        test_fault_injection();
        test_loop_stop();
        test_ignored_controls();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aging_vec_engine.md
# aging_vec_engine

Synthesizable, parametrised stimulus/response engine for ISCAS-85 aging experiments. It stores a vector table with expected responses and drives each vector onto a combinational benchmark's inputs. Each vector is held for a programmable settle time before the benchmark's outputs are sampled, compared and reported. It replaces file-driven benches for long stress runs and adds looping, pass counting and a mismatch log.

## Interface
- IN_W, 5: vector width driven to the DUT.
- OUT_W, 2: DUT response width.
- DEPTH, 30: number of table entries; minimum 2.
- AW, $clog2(DEPTH): table address width.
- SETTLE, 1: cycles each vector is held before its response is sampled; minimum 1.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write one table entry this cycle.
- load_addr  in  AW  entry index; writes with load_addr >= DEPTH are dropped.
- load_vec  in  IN_W  stimulus word written to the entry.
- load_exp  in  OUT_W  expected response written to the entry.
- start  in  1  one-cycle pulse that begins a run from entry 0.
- loop_mode  in  1  sampled with start; 1 = repeat the table until stop.
- stop  in  1  in loop mode, finish the current vector, then end.
- dut_in  out  IN_W  vector applied to the DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run ends.
- vec_idx  out  AW  index of the vector currently applied.
- resp_valid  out  1  one-cycle strobe when a response is sampled.
- resp_data  out  OUT_W  sampled response, valid with resp_valid.
- mismatch_cnt  out  16  saturating count of compare failures.
- pass_cnt  out  16  completed table passes; wraps at 16'hFFFF.
- first_fail_valid  out  1  a mismatch has been logged this run.
- first_fail_idx  out  AW  index of the first mismatching vector.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE:
  - load_en writes the table.
  - start moves the engine to APPLY with vec_idx=0 and hold counter=0.
  - start clears mismatch_cnt, pass_cnt and first_fail_valid.
  - start latches loop_mode.
- APPLY:
  - dut_in = table[vec_idx].vec.
  - The hold counter runs 0..SETTLE-1. At SETTLE-1, dut_out is sampled and resp_valid pulses.
  - dut_out is compared against table[vec_idx].exp.
  - On inequality, mismatch_cnt increments, saturating at 16'hFFFF.
  - If first_fail_valid=0 on a mismatch, first_fail_idx is set to vec_idx and first_fail_valid to 1.
- End of the last vector (vec_idx=DEPTH-1):
  - pass_cnt increments.
  - Loop off: go to DONE.
  - Loop on, stop not seen: vec_idx wraps to 0.
- stop in loop mode is sticky once seen. The engine goes to DONE at the next vector boundary, after that vector's compare. The partial pass is not counted.
- DONE lasts one cycle, asserts done, then returns to IDLE. Results are held until the next start.
- Ignored inputs:
  - load_en is ignored while busy. The table is not modified mid-run.
  - start is ignored while busy.
  - stop outside loop mode has no effect.
- rst mid-run returns the engine to IDLE immediately and clears all outputs. Table contents are not reset.

## Timing
- Reset values: dut_in=0, busy=0, done=0, vec_idx=0, resp_valid=0, resp_data=0, mismatch_cnt=0, pass_cnt=0, first_fail_valid=0, first_fail_idx=0.
- start sampled at edge t:
  - busy=1 and dut_in=vector 0 from edge t+1.
  - The first resp_valid appears at edge t+SETTLE.
- Each vector occupies exactly SETTLE cycles. There is no gap between vectors.
- A non-loop run ends with done at edge t+DEPTH*SETTLE+1. busy falls in the same cycle.
- dut_in, vec_idx and resp_data are registered. dut_out is sampled at the rising edge, so the DUT path must fit within SETTLE cycles.
- Comparator and counter updates happen in the same cycle as resp_valid. They are visible on the following cycle.

## Test plan
- Reset mid-run, then check defaults:
  - Stimulus: load DEPTH=30 entries, start, assert rst at vector 10.
  - Response: all outputs return to reset values at once.
  - Stimulus: start again.
  - Response: the table still replays correctly.
- Golden c17 at SETTLE=1:
  - Stimulus: load exhaustive-ish c17 vectors with correct expectations, loop_mode=0.
  - Response: 30 resp_valid strobes, mismatch_cnt=0, pass_cnt=1, done one cycle after the last strobe.
- Fault injection at SETTLE=3:
  - Stimulus: corrupt the expectations at entries 4 and 17.
  - Response: mismatch_cnt=2, first_fail_idx=4, resp_valid every 3 cycles.
- Loop with stop:
  - Stimulus: loop_mode=1, stop pulsed during pass 3 at vector 12.
  - Response: pass_cnt=2, last resp_valid at vector 12, then done.
- Ignored controls:
  - Stimulus: load_en and start asserted while busy.
  - Response: table unchanged on the next run, run not restarted.
  - Stimulus: load_addr=31.
  - Response: write dropped.
- Saturation:
  - Stimulus: DEPTH=2, all-wrong expectations, loop for more than 32768 passes.
  - Response: mismatch_cnt holds at 16'hFFFF.
